trng_packer: RTL and testbench
==============================

Name: trng_packer

Overview:
- Parametrised successor of the TRNG shift stage. Packs Bpc-bit comparator chunks into Dbw-bit words for the AXI4-Lite readout path.
- Adds a Depth-word FWFT output FIFO with a lossless valid/ready handshake, explicit drop accounting, a flush, and occupancy reporting.
- Sits between the TRNG comparator/sampler and the AXI register/readout logic.

Parameters:
- Dbw, 32: output word width (32 or 64).
- Bpc, 4: bits per input chunk; any value with Dbw % Bpc == 0, 1 <= Bpc <= Dbw.
- Depth, 4: output FIFO depth in words; power of two, >= 2.
- DcntW, 16: width of the drop counter.

Ports:
- clock  in  1  global clock
- reset  in  1  synchronous, active-high reset
- en_sr  in  1  shift_in holds a valid chunk this cycle
- shift_in  in  Bpc  input chunk
- flush  in  1  discard the partial word and all FIFO contents
- clr_ovf  in  1  clear the overflow flag and drop_cnt
- out_ready  in  1  consumer accepts out_data
- out_data  out  Dbw  FIFO head word
- out_valid  out  1  FIFO not empty
- level  out  $clog2(Depth+1)  words held in the FIFO
- partial  out  $clog2(Dbw/Bpc)+1  chunks in the current unfinished word
- overflow  out  1  sticky: a complete word was dropped
- drop_cnt  out  DcntW  saturating count of dropped words

Behaviour:
- Reset values: out_valid=0, level=0, partial=0, overflow=0, drop_cnt=0, out_data=0. Reset clears the assembler and the FIFO, including mid-word and mid-drain.
- Priority: reset > flush > normal operation. clr_ovf is independent of flush.
- Let N = Dbw/Bpc.
- Assembly: on each en_sr, the assembler shifts left by Bpc and inserts shift_in at the LSBs, so the first chunk ends up in the MSBs. The chunk counter increments.
- Word completion: when the chunk counter is at N-1 and en_sr=1, the completed word, including the current chunk, is pushed at that same edge and the counter returns to 0.
- N == 1 (Bpc == Dbw): every en_sr pushes shift_in directly; there is no assembly register.
- FIFO is first-word-fall-through: out_data = head word, out_valid = (level != 0).
- Pop occurs on a cycle with out_valid && out_ready.
- Latency: the edge that completes a word into an empty FIFO makes out_valid=1 in the following cycle, with out_data equal to that word.
- Simultaneous push and pop:
  - FIFO not full: level is unchanged.
  - FIFO full: the push is accepted because the pop frees a slot; no drop.
- Full with push and no pop: the word is discarded and FIFO contents are untouched. overflow is set, and drop_cnt increments, saturating at all-ones.
- clr_ovf: overflow and drop_cnt go to 0 at the next edge. If a drop happens in the same cycle, the drop wins: overflow=1 and drop_cnt=1.
- flush: at the next edge, partial=0 and level=0 and the assembler is zeroed. The en_sr chunk and any pop in that cycle are ignored. overflow and drop_cnt are kept.
- out_data is stable while out_valid=1 and out_ready=0. Data never changes under a stalled handshake.
- Pointer wrap: read/write pointers are $clog2(Depth) bits plus one wrap bit; level is derived from their difference.
- en_sr while the FIFO is full but the word is still incomplete: the chunk is accepted normally. Drops happen only on word completion.

Decomposition:
- Shared include trng_defs.vh: legal Bpc/Dbw combination checks, default Depth, DcntW, and the `TRNG_CLOG2 helper for level/partial widths.
- Natural sub-module: trng_word_fifo, a Dbw x Depth FWFT FIFO with push/pop/flush, full/empty and level. The packer instantiates it.
- Assembler and drop accounting stay in trng_packer.

Test Plan:
- Basic assembly (Dbw=32, Bpc=4, Depth=4): 8 consecutive en_sr with nibbles 1,2,...,8 and out_ready=1 -> out_valid=1 one cycle after the 8th edge, out_data=0x12345678, single-cycle valid, then level=0.
- Overflow: out_ready=0, feed 5 words 0x11111111..0x55555555 -> level=4, overflow=1, drop_cnt=1. Then out_ready=1 -> reads 0x11111111..0x44444444 in order, and out_valid drops after the 4th read.
- Full with simultaneous pop: FIFO full, complete a word on the same cycle as out_ready=1 -> no drop, drop_cnt=0, level stays 4, new word read last.
- Flush / reset mid-word: 3 nibbles (partial=3), then flush, then nibbles 9,A,B,C,D,E,F,0 -> out_data=0x9ABCDEF0. Repeat with reset in place of flush -> same result, overflow=0.
- Widths: Dbw=32, Bpc=32 -> each en_sr with 0xDEADBEEF gives the same word next cycle. Dbw=64, Bpc=2 -> 32 chunks of 2'b10 give 0xAAAAAAAAAAAAAAAA.
- Counter saturation and clear (DcntW=4): 20 drops -> drop_cnt=15. Then clr_ovf -> overflow=0, drop_cnt=0. clr_ovf coincident with a drop -> drop_cnt=1, overflow=1.

Source files
------------

// File: rtl/trng_packer_pkg.sv
// Shared defaults for the TRNG packing path.
package trng_packer_pkg;

    localparam int DEF_DBW   = 32;
    localparam int DEF_BPC   = 4;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_DCNTW = 16;

endpackage

// File: rtl/trng_packer_if.sv
// Chunk input and word readout handshake between sampler, packer and readout logic.
interface trng_packer_if #(
    parameter int Dbw = 32,
    parameter int Bpc = 4
);
    logic           en_sr;
    logic [Bpc-1:0] shift_in;
    logic           out_ready;
    logic [Dbw-1:0] out_data;
    logic           out_valid;

    modport master (
        input  en_sr,
        input  shift_in,
        input  out_ready,
        output out_data,
        output out_valid
    );

    modport slave (
        output en_sr,
        output shift_in,
        output out_ready,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/trng_word_fifo.sv
// Dbw x Depth first-word-fall-through FIFO with flush and occupancy.
// Latency: a push is visible at rd_data the cycle after the write edge.
// Backpressure: push while full is ignored unless a pop frees the slot in the same cycle.
module trng_word_fifo
    import trng_packer_pkg::*;
#(
    parameter int Dbw   = DEF_DBW,
    parameter int Depth = DEF_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [Dbw-1:0]               wr_data,
    output logic [Dbw-1:0]               rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(Depth+1)-1:0]   level
);
    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [Dbw-1:0] mem [Depth];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/trng_packer.sv
// Packs Bpc-bit TRNG chunks MSB-first into Dbw-bit words queued in an FWFT FIFO.
// Latency: the word-completing edge makes out_valid high in the following cycle.
// Backpressure: valid/ready on output; a word completing into a full FIFO with no pop is dropped and counted.
module trng_packer
    import trng_packer_pkg::*;
#(
    parameter int Dbw   = DEF_DBW,
    parameter int Bpc   = DEF_BPC,
    parameter int Depth = DEF_DEPTH,
    parameter int DcntW = DEF_DCNTW
) (
    input  logic                          clock,
    input  logic                          reset,
    trng_packer_if.master                 bus,
    input  logic                          flush,
    input  logic                          clr_ovf,
    output logic [$clog2(Depth+1)-1:0]    level,
    output logic [$clog2(Dbw/Bpc):0]      partial,
    output logic                          overflow,
    output logic [DcntW-1:0]              drop_cnt
);
    localparam int N  = Dbw / Bpc;
    localparam int PW = $clog2(N) + 1;

    logic           word_done;
    logic [Dbw-1:0] word_dat;
    logic           push;
    logic           pop;
    logic           drop;
    logic           fifo_full;
    logic           fifo_empty;

    generate
        if (N == 1) begin : g_direct
            assign word_done = bus.en_sr;
            assign word_dat  = bus.shift_in;
            assign partial   = '0;
        end else begin : g_asm
            logic [PW-1:0]      cnt;
            logic [Dbw-Bpc-1:0] asm_q;

            assign word_done = bus.en_sr && (cnt == PW'(N - 1));
            assign word_dat  = {asm_q, bus.shift_in};
            assign partial   = cnt;

            always_ff @(posedge clock) begin
                if (reset || flush) begin
                    cnt   <= '0;
                    asm_q <= '0;
                end else if (bus.en_sr) begin
                    asm_q <= word_dat[Dbw-Bpc-1:0];
                    cnt   <= word_done ? '0 : cnt + PW'(1);
                end
            end
        end
    endgenerate

    // Flush swallows both the incoming chunk and any pop in the same cycle.
    assign pop           = bus.out_valid && bus.out_ready && !flush;
    assign push          = word_done && !flush;
    assign drop          = push && fifo_full && !pop;
    assign bus.out_valid = !fifo_empty;

    trng_word_fifo #(
        .Dbw   (Dbw),
        .Depth (Depth)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (word_dat),
        .rd_data (bus.out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // A drop in the same cycle as clr_ovf restarts the count at one.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf)        drop_cnt <= DcntW'(1);
            else if (!(&drop_cnt)) drop_cnt <= drop_cnt + DcntW'(1);
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_trng_packer.sv
// Directed bench for trng_packer: queue scoreboard on the 32/4 build, directed checks on 32/32 and 64/2.
module tb_trng_packer;

    logic clock;
    logic rst_a, flush_a, clr_a;
    logic rst_bc;

    logic [2:0]  a_level;
    logic [3:0]  a_partial;
    logic        a_ovf;
    logic [3:0]  a_dcnt;

    logic [2:0]  b_level;
    logic [0:0]  b_partial;
    logic        b_ovf;
    logic [15:0] b_dcnt;

    logic [2:0]  c_level;
    logic [5:0]  c_partial;
    logic        c_ovf;
    logic [15:0] c_dcnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    int          m_cnt  = 0;
    logic [31:0] m_asm  = '0;
    logic        m_ovf  = 1'b0;
    int          m_dcnt = 0;

    trng_packer_if #(.Dbw(32), .Bpc(4))  a_if ();
    trng_packer_if #(.Dbw(32), .Bpc(32)) b_if ();
    trng_packer_if #(.Dbw(64), .Bpc(2))  c_if ();

    trng_packer #(.Dbw(32), .Bpc(4), .Depth(4), .DcntW(4)) u_a (
        .clock(clock), .reset(rst_a), .bus(a_if), .flush(flush_a), .clr_ovf(clr_a),
        .level(a_level), .partial(a_partial), .overflow(a_ovf), .drop_cnt(a_dcnt)
    );

    trng_packer #(.Dbw(32), .Bpc(32), .Depth(4), .DcntW(16)) u_b (
        .clock(clock), .reset(rst_bc), .bus(b_if), .flush(1'b0), .clr_ovf(1'b0),
        .level(b_level), .partial(b_partial), .overflow(b_ovf), .drop_cnt(b_dcnt)
    );

    trng_packer #(.Dbw(64), .Bpc(2), .Depth(4), .DcntW(16)) u_c (
        .clock(clock), .reset(rst_bc), .bus(c_if), .flush(1'b0), .clr_ovf(1'b0),
        .level(c_level), .partial(c_partial), .overflow(c_ovf), .drop_cnt(c_dcnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle on the 32/4 build: drive, check head against scoreboard, update model, check status.
    task automatic a_cycle(input logic en, input logic [3:0] nib, input logic rdy,
                           input logic fl, input logic clr, input logic rst);
        bit done;
        bit drop;
        a_if.en_sr     = en;
        a_if.shift_in  = nib;
        a_if.out_ready = rdy;
        flush_a        = fl;
        clr_a          = clr;
        rst_a          = rst;
        #4;
        chk("a_out_valid", a_if.out_valid, q.size() != 0);
        if (q.size() != 0) chk("a_out_data", a_if.out_data, q[0]);
        done = 1'b0;
        drop = 1'b0;
        if (rst) begin
            q.delete(); m_cnt = 0; m_asm = '0; m_ovf = 1'b0; m_dcnt = 0;
        end else if (fl) begin
            q.delete(); m_cnt = 0; m_asm = '0;
            if (clr) begin m_ovf = 1'b0; m_dcnt = 0; end
        end else begin
            if (rdy && q.size() != 0) void'(q.pop_front());
            if (en) begin
                m_asm = {m_asm[27:0], nib};
                if (m_cnt == 7) begin done = 1'b1; m_cnt = 0; end
                else m_cnt++;
            end
            if (done) begin
                if (q.size() < 4) q.push_back(m_asm);
                else drop = 1'b1;
            end
            if (drop) begin
                m_ovf  = 1'b1;
                m_dcnt = clr ? 1 : ((m_dcnt == 15) ? 15 : m_dcnt + 1);
            end else if (clr) begin
                m_ovf = 1'b0; m_dcnt = 0;
            end
        end
        @(posedge clock);
        #1;
        chk("a_level", a_level, q.size());
        chk("a_partial", a_partial, m_cnt);
        chk("a_overflow", a_ovf, m_ovf);
        chk("a_drop_cnt", a_dcnt, m_dcnt);
    endtask

    task automatic a_idle(input logic rdy);
        a_cycle(1'b0, 4'h0, rdy, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic a_word(input logic [31:0] w, input logic rdy, input logic clr_last);
        for (int i = 0; i < 8; i++) begin
            logic [3:0] n;
            n = w[31-4*i -: 4];
            a_cycle(1'b1, n, rdy, 1'b0, clr_last && (i == 7), 1'b0);
        end
    endtask

    initial begin
        logic [31:0] w;
        a_if.en_sr = 0; a_if.shift_in = '0; a_if.out_ready = 0;
        b_if.en_sr = 0; b_if.shift_in = '0; b_if.out_ready = 0;
        c_if.en_sr = 0; c_if.shift_in = '0; c_if.out_ready = 0;
        flush_a = 0; clr_a = 0; rst_a = 1; rst_bc = 1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_a_valid", a_if.out_valid, 1'b0);
        chk("rst_a_data", a_if.out_data, 32'h0);
        chk("rst_a_level", a_level, 0);
        chk("rst_a_partial", a_partial, 0);
        chk("rst_a_ovf", a_ovf, 1'b0);
        chk("rst_a_dcnt", a_dcnt, 0);
        chk("rst_b_valid", b_if.out_valid, 1'b0);
        chk("rst_c_valid", c_if.out_valid, 1'b0);
        chk("rst_c_data", c_if.out_data, 64'h0);
        rst_a = 0; rst_bc = 0;

        // Basic assembly with the consumer always ready
        for (int i = 0; i < 8; i++) a_cycle(1'b1, 4'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("basic_valid", a_if.out_valid, 1'b1);
        chk("basic_word", a_if.out_data, 32'h12345678);
        a_idle(1'b1);
        chk("basic_single_vld", a_if.out_valid, 1'b0);
        chk("basic_level", a_level, 0);

        // Overflow on the fifth word, then ordered drain
        for (int k = 1; k <= 5; k++) begin
            w = 32'h11111111 * k;
            a_word(w, 1'b0, 1'b0);
        end
        chk("ovf_level", a_level, 4);
        chk("ovf_flag", a_ovf, 1'b1);
        chk("ovf_dcnt", a_dcnt, 1);
        chk("ovf_head", a_if.out_data, 32'h11111111);
        repeat (4) a_idle(1'b1);
        chk("ovf_drained", a_if.out_valid, 1'b0);
        a_cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_flag", a_ovf, 1'b0);
        chk("clr_dcnt", a_dcnt, 0);

        // Full FIFO: chunks still accepted, completion with a pop is not a drop
        for (int k = 6; k <= 9; k++) begin
            w = 32'h11111111 * k;
            a_word(w, 1'b0, 1'b0);
        end
        for (int i = 0; i < 7; i++) a_cycle(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_partial", a_partial, 7);
        a_cycle(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fullpop_level", a_level, 4);
        chk("fullpop_dcnt", a_dcnt, 0);
        chk("fullpop_ovf", a_ovf, 1'b0);
        repeat (3) a_idle(1'b1);
        chk("fullpop_last", a_if.out_data, 32'hEEEEEEEE);
        a_idle(1'b1);

        // Flush mid-word with a word queued, chunk and pop during flush ignored
        a_word(32'h12345678, 1'b0, 1'b0);
        a_cycle(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        a_cycle(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        a_cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_pre_partial", a_partial, 3);
        a_cycle(1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("flush_level", a_level, 0);
        chk("flush_partial", a_partial, 0);
        a_word(32'h9ABCDEF0, 1'b0, 1'b0);
        chk("flush_word", a_if.out_data, 32'h9ABCDEF0);
        a_idle(1'b1);

        // Drop counter saturation, clear, and clear coincident with a drop
        for (int k = 0; k < 24; k++) begin
            w = 32'h0F0F0F00 + 32'(k);
            a_word(w, 1'b0, 1'b0);
        end
        chk("sat_dcnt", a_dcnt, 15);
        a_cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sat_clr_dcnt", a_dcnt, 0);
        chk("sat_clr_ovf", a_ovf, 1'b0);
        for (int k = 0; k < 3; k++) a_word(32'hCAFE0000 + 32'(k), 1'b0, 1'b0);
        chk("drops3", a_dcnt, 3);
        a_word(32'hBEEF0001, 1'b0, 1'b1);
        chk("clrdrop_dcnt", a_dcnt, 1);
        chk("clrdrop_ovf", a_ovf, 1'b1);
        repeat (4) a_idle(1'b1);

        // Reset mid-word
        a_cycle(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        a_cycle(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        a_cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        a_cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        a_word(32'h9ABCDEF0, 1'b0, 1'b0);
        chk("rstmid_word", a_if.out_data, 32'h9ABCDEF0);
        chk("rstmid_ovf", a_ovf, 1'b0);
        a_idle(1'b1);

        // Bpc == Dbw: every chunk is a word
        b_if.en_sr = 1; b_if.shift_in = 32'hDEADBEEF; b_if.out_ready = 1;
        @(posedge clock); #1;
        chk("b_valid", b_if.out_valid, 1'b1);
        chk("b_word", b_if.out_data, 32'hDEADBEEF);
        chk("b_level", b_level, 1);
        b_if.shift_in = 32'h0BADF00D;
        @(posedge clock); #1;
        chk("b_word2", b_if.out_data, 32'h0BADF00D);
        chk("b_level2", b_level, 1);
        b_if.en_sr = 0;
        @(posedge clock); #1;
        chk("b_empty", b_if.out_valid, 1'b0);
        chk("b_partial", b_partial, 0);
        chk("b_ovf", b_ovf, 1'b0);
        chk("b_dcnt", b_dcnt, 0);

        // Dbw=64, Bpc=2
        c_if.en_sr = 1; c_if.shift_in = 2'b10; c_if.out_ready = 0;
        repeat (16) @(posedge clock);
        #1;
        chk("c_partial16", c_partial, 16);
        chk("c_not_valid", c_if.out_valid, 1'b0);
        repeat (16) @(posedge clock);
        #1;
        c_if.en_sr = 0;
        chk("c_partial0", c_partial, 0);
        chk("c_valid", c_if.out_valid, 1'b1);
        chk("c_word", c_if.out_data, 64'hAAAAAAAAAAAAAAAA);
        chk("c_level", c_level, 1);
        c_if.out_ready = 1;
        @(posedge clock); #1;
        chk("c_empty", c_if.out_valid, 1'b0);
        chk("c_ovf", c_ovf, 1'b0);
        chk("c_dcnt", c_dcnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
